// File: rtl/sr_cmd_conditioner.sv
// Purpose : synchronise and debounce two raw push-buttons, then turn debounced
//           rising edges into clean, mutually exclusive s/r pulses.
// Latency : raw edge to s/r/busy high is DEBOUNCE_CYCLES+2 clocks. There is no
//           backpressure; a one-deep pending slot absorbs a request that arrives
//           while a pulse or gap is in progress, and a newer request replaces it.
// Ports   : clk, rst_n (sync, active-low), set_btn/rst_btn (raw async, active high),
//           s/r (pulses), busy (FSM not idle), conflict (simultaneous requests).
// Config  : SR_CMD_RESET_PRIORITY_EN -- when defined, simultaneous requests take
//           the reset (conflict still flags); otherwise they are dropped.
module sr_cmd_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned PULSE_CYCLES    = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic set_btn,
   input  logic rst_btn,
   output logic s,
   output logic r,
   output logic busy,
   output logic conflict
);

   localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SET_P, RST_P, GAP} state_t;

   // channel 0 = set, channel 1 = reset
   logic [1:0] btn;
   logic [1:0] sync1_q, sync2_q, db_q, db_prev_q;
   logic [7:0] cnt_q [2];

   state_t     state_q, state_d;
   logic [3:0] pcnt_q, pcnt_d;
   logic       pend_vld_q, pend_vld_d;
   logic       pend_rst_q, pend_rst_d;
   logic       s_d, r_d, busy_d, conflict_d;

   logic       set_req, rst_req, both_req;
   logic       take_set, take_rst;
   logic       svc_vld, svc_rst;

   assign btn = {rst_btn, set_btn};

   // Synchroniser, debounce and edge-detect history
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         for (int c = 0; c < 2; c++) cnt_q[c] <= '0;
      end else begin
         sync1_q   <= btn;
         sync2_q   <= sync1_q;
         db_prev_q <= db_q;
         for (int c = 0; c < 2; c++) begin
            if (sync2_q[c] == db_q[c]) begin
               cnt_q[c] <= '0;
            end else if (cnt_q[c] == DB_LAST) begin
               db_q[c]  <= sync2_q[c];
               cnt_q[c] <= '0;
            end else begin
               cnt_q[c] <= cnt_q[c] + 8'd1;
            end
         end
      end
   end

   assign set_req  = db_q[0] & ~db_prev_q[0];
   assign rst_req  = db_q[1] & ~db_prev_q[1];
   assign both_req = set_req & rst_req;

   // Resolve which single request (if any) this cycle actually carries.
   assign take_set = set_req & ~rst_req;
`ifdef SR_CMD_RESET_PRIORITY_EN
   assign take_rst = rst_req;
`else
   assign take_rst = rst_req & ~set_req;
`endif

   // In GAP a fresh request is the newest one, so it wins over the pending slot.
   assign svc_vld = take_set | take_rst | pend_vld_q;
   assign svc_rst = (take_set | take_rst) ? take_rst : pend_rst_q;

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         pcnt_q     <= '0;
         pend_vld_q <= 1'b0;
         pend_rst_q <= 1'b0;
         s          <= 1'b0;
         r          <= 1'b0;
         busy       <= 1'b0;
         conflict   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pcnt_q     <= pcnt_d;
         pend_vld_q <= pend_vld_d;
         pend_rst_q <= pend_rst_d;
         s          <= s_d;
         r          <= r_d;
         busy       <= busy_d;
         conflict   <= conflict_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      pcnt_d     = pcnt_q;
      pend_vld_d = pend_vld_q;
      pend_rst_d = pend_rst_q;
      case (state_q)
         IDLE: begin
            pcnt_d = '0;
            if (take_set)      state_d = SET_P;
            else if (take_rst) state_d = RST_P;
         end
         SET_P, RST_P: begin
            if (take_set | take_rst) begin
               pend_vld_d = 1'b1;
               pend_rst_d = take_rst;
            end
            if (pcnt_q == PULSE_LAST) state_d = GAP;
            else                      pcnt_d  = pcnt_q + 4'd1;
         end
         GAP: begin
            pcnt_d     = '0;
            pend_vld_d = 1'b0;
            pend_rst_d = 1'b0;
            if (svc_vld) state_d = svc_rst ? RST_P : SET_P;
            else         state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Output logic: decoded from the next state so outputs align with the state flop
   always_comb begin
      s_d        = (state_d == SET_P);
      r_d        = (state_d == RST_P);
      busy_d     = (state_d != IDLE);
      conflict_d = both_req;
   end

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
module tb_sr_cmd_conditioner;

   localparam int N  = 4;
   localparam int NI = 3;
   localparam int PW [NI] = '{1, 3, 8};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic set_btn = 1'b0;
   logic rst_btn = 1'b0;
   logic [NI-1:0] s_o, r_o, busy_o, conf_o;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   sr_cmd_conditioner #(.DEBOUNCE_CYCLES(N), .PULSE_CYCLES(1)) u_p1 (
      .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .rst_btn(rst_btn),
      .s(s_o[0]), .r(r_o[0]), .busy(busy_o[0]), .conflict(conf_o[0]));
   sr_cmd_conditioner #(.DEBOUNCE_CYCLES(N), .PULSE_CYCLES(3)) u_p3 (
      .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .rst_btn(rst_btn),
      .s(s_o[1]), .r(r_o[1]), .busy(busy_o[1]), .conflict(conf_o[1]));
   sr_cmd_conditioner #(.DEBOUNCE_CYCLES(N), .PULSE_CYCLES(8)) u_p8 (
      .clk(clk), .rst_n(rst_n), .set_btn(set_btn), .rst_btn(rst_btn),
      .s(s_o[2]), .r(r_o[2]), .busy(busy_o[2]), .conflict(conf_o[2]));

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Debounce: level flips once the last N synchronised samples all disagree with it.
   // Scheduler: timeline of pulses; a pulse started after edge st covers edges
   // st..st+P-1, the gap is edge st+P.
   int   k = 0;
   logic s1m [2];
   logic dbm [2];
   logic dbpm [2];
   logic hist0 [$];
   logic hist1 [$];
   int   st [NI];
   int   kind [NI];   // 1 = set, 2 = reset
   int   pend [NI];
   logic both_m;

   function automatic bit all_diff(input logic q [$], input logic d);
      if (q.size() < N) return 1'b0;
      foreach (q[i]) if (q[i] == d) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         s1m[c] = 1'b0; dbm[c] = 1'b0; dbpm[c] = 1'b0;
      end
      hist0.delete();
      hist1.delete();
      for (int i = 0; i < NI; i++) begin
         st[i] = -1000; kind[i] = 0; pend[i] = 0;
      end
      both_m = 1'b0;
   endtask

   task automatic model_step();
      logic sreq, rreq, ns;
      int   tk, eff, gap, prev;
      k++;
      if (!rst_n) begin
         model_reset();
      end else begin
         sreq   = dbm[0] & ~dbpm[0];
         rreq   = dbm[1] & ~dbpm[1];
         both_m = sreq & rreq;
         tk = 0;
         if (sreq && !rreq)      tk = 1;
         else if (rreq && !sreq) tk = 2;
`ifdef SR_CMD_RESET_PRIORITY_EN
         else if (sreq && rreq)  tk = 2;
`endif
         prev = k - 1;
         for (int i = 0; i < NI; i++) begin
            gap = st[i] + PW[i];
            if (prev > gap) begin
               if (tk != 0) begin st[i] = k; kind[i] = tk; end
            end else if (prev < gap) begin
               if (tk != 0) pend[i] = tk;
            end else begin
               eff = (tk != 0) ? tk : pend[i];
               pend[i] = 0;
               if (eff != 0) begin st[i] = k; kind[i] = eff; end
            end
         end
         dbpm[0] = dbm[0];
         dbpm[1] = dbm[1];
         if (all_diff(hist0, dbm[0])) dbm[0] = ~dbm[0];
         if (all_diff(hist1, dbm[1])) dbm[1] = ~dbm[1];
         ns = s1m[0]; s1m[0] = set_btn; hist0.push_back(ns);
         ns = s1m[1]; s1m[1] = rst_btn; hist1.push_back(ns);
         if (hist0.size() > N) void'(hist0.pop_front());
         if (hist1.size() > N) void'(hist1.pop_front());
      end
      for (int i = 0; i < NI; i++) begin
         int in_p, in_b;
         in_p = (k >= st[i]) && (k <= st[i] + PW[i] - 1);
         in_b = (k >= st[i]) && (k <= st[i] + PW[i]);
         chk($sformatf("s[P%0d]", PW[i]),    s_o[i],    int'(in_p && kind[i] == 1));
         chk($sformatf("r[P%0d]", PW[i]),    r_o[i],    int'(in_p && kind[i] == 2));
         chk($sformatf("busy[P%0d]", PW[i]), busy_o[i], in_b);
         chk($sformatf("conflict[P%0d]", PW[i]), conf_o[i], int'(both_m));
         chk($sformatf("s_and_r[P%0d]", PW[i]), s_o[i] & r_o[i], 0);
      end
   endtask

   // Drive inputs on the falling edge, check just after the rising edge.
   task automatic tick(input logic sb, input logic rb, input logic rn);
      @(negedge clk);
      set_btn = sb;
      rst_btn = rb;
      rst_n   = rn;
      @(posedge clk);
      #1;
      model_step();
   endtask

   task automatic hold(input logic sb, input logic rb, input int cyc);
      for (int j = 0; j < cyc; j++) tick(sb, rb, 1'b1);
   endtask

   initial begin
      model_reset();
      // reset with both buttons held, then release reset while held
      for (int j = 0; j < 3; j++) tick(1'b1, 1'b1, 1'b0);
      hold(1'b1, 1'b1, 12);
      hold(1'b0, 1'b0, 10);
      // basic set
      hold(1'b1, 1'b0, 12);
      hold(1'b0, 1'b0, 10);
      // glitch rejection
      hold(1'b1, 1'b0, 3);
      hold(1'b0, 1'b0, 10);
      // queued reset while set pulse is running
      hold(1'b1, 1'b0, 2);
      hold(1'b1, 1'b1, 20);
      hold(1'b0, 1'b0, 10);
      // simultaneous rise
      hold(1'b1, 1'b1, 12);
      hold(1'b0, 1'b0, 10);
      // reset during the 4th cycle of an 8-cycle pulse
      hold(1'b1, 1'b0, N + 2 + 3);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      hold(1'b0, 1'b0, 20);
      // randomised segments
      for (int seg = 0; seg < 400; seg++) begin
         logic sb, rb;
         int   len;
         sb  = 1'($urandom_range(0, 1));
         rb  = 1'($urandom_range(0, 1));
         len = $urandom_range(1, 14);
         if ($urandom_range(0, 24) == 0) begin
            for (int j = 0; j < $urandom_range(1, 3); j++) tick(sb, rb, 1'b0);
         end
         hold(sb, rb, len);
      end
      hold(1'b0, 1'b0, 20);
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
